adc_scan_scheduler: RTL and testbench

- Sequencer between the control logic and the ADC128S052 capture block.
- Scans an 8-bit mask of analog inputs IN0-IN7, either once or continuously.
- Drives the capture block's enable, address and acknowledge. Accounts for the converter's one-frame address pipeline: data returned in frame N belongs to the address presented during frame N-1.
- Stores the latest result per channel and streams each sample out.

---
 rtl/adc_scan_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Scan sequencer for the ADC128S052 capture block: walks a channel mask, tracks the
// converter's one-frame address pipeline, banks and streams results. Optional ADC_SCAN_AVG_EN averages 4 frames.
module adc_scan_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FIRST_CHAN     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [7:0]  chan_mask,
  input  logic        adc_ready,
  input  logic [11:0] adc_data,
  output logic        adc_en,
  output logic [2:0]  adc_address,
  output logic        adc_ack,
  output logic        busy,
  output logic        sample_valid,
  output logic [2:0]  sample_chan,
  output logic [11:0] sample_data,
  output logic        scan_done,
  output logic        timeout_err,
  input  logic [2:0]  rd_chan,
  output logic [11:0] rd_data,
  output logic        rd_valid
);

  localparam int          TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  FC = 3'(FIRST_CHAN);

  typedef enum logic [1:0] {IDLE, PRIME, WAIT_RDY, ACK} state_t;

  state_t        state, state_d;
  logic [7:0]    mask_q;
  logic          cont_q;
  logic [2:0]    cur;
  logic [2:0]    first_q;
  logic [2:0]    nxt;
  logic          end_q;
  logic          stop_pend;
  logic          stop_ok;
  logic [TW-1:0] tcnt;
  logic [11:0]   bank [8];
  logic [7:0]    valid_q;

  logic accept, rdy_evt, ack_exit, finish, tmo;

  // Set bit of m at/after 'from' (incl=1) or strictly after it, wrapping 7->0.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] from,
                                           input logic incl);
    logic [2:0] c;
    logic [2:0] r;
    logic       found;
    r     = from;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = from + 3'(i) + (incl ? 3'd0 : 3'd1);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign nxt = next_chan(mask_q, cur, 1'b0);

`ifdef ADC_SCAN_AVG_EN
  logic [2:0]  phase;
  logic [13:0] acc;
  logic [13:0] acc_sum;
  logic        bnd_q;

  function automatic logic [11:0] avg_trunc(input logic [13:0] a);
    return a[13:2];
  endfunction

  assign acc_sum = acc + {2'b00, adc_data};
  // Stop may only land right after a completed 4-sample average.
  assign stop_ok = bnd_q;
`else
  logic [2:0] prev;
  logic       final_q;

  assign stop_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    rdy_evt  = 1'b0;
    ack_exit = 1'b0;
    finish   = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (chan_mask != 8'd0)) begin
          accept  = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME, WAIT_RDY: begin
        if (adc_ready) begin
          rdy_evt = 1'b1;
          state_d = ACK;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!adc_ready) begin
          ack_exit = 1'b1;
          finish   = end_q || ((stop_pend || stop) && stop_ok);
          state_d  = finish ? IDLE : WAIT_RDY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_en       <= 1'b0;
      adc_address  <= '0;
      adc_ack      <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_data  <= '0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      cur          <= '0;
      first_q      <= '0;
      end_q        <= 1'b0;
      stop_pend    <= 1'b0;
      tcnt         <= '0;
      valid_q      <= '0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
      phase        <= '0;
      acc          <= '0;
      bnd_q        <= 1'b0;
`else
      prev         <= '0;
      final_q      <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;

      if ((state == PRIME) || (state == WAIT_RDY)) tcnt <= adc_ready ? '0 : tcnt + 1'b1;
      else                                         tcnt <= '0;

      if (busy && stop) stop_pend <= 1'b1;

      if (accept) begin
        mask_q      <= chan_mask;
        cont_q      <= continuous;
        cur         <= next_chan(chan_mask, FC, 1'b1);
        first_q     <= next_chan(chan_mask, FC, 1'b1);
        adc_address <= next_chan(chan_mask, FC, 1'b1);
        valid_q     <= '0;
        timeout_err <= 1'b0;
        adc_en      <= 1'b1;
        busy        <= 1'b1;
        end_q       <= 1'b0;
        stop_pend   <= 1'b0;
        tcnt        <= '0;
`ifdef ADC_SCAN_AVG_EN
        phase       <= '0;
        acc         <= '0;
        bnd_q       <= 1'b0;
`else
        final_q     <= 1'b0;
`endif
      end

      // Frame boundary: capture block is paused, so the address may move here only.
      if (rdy_evt) begin
        adc_ack <= 1'b1;
`ifdef ADC_SCAN_AVG_EN
        bnd_q <= 1'b0;
        if (phase == 3'd0) begin
          phase <= 3'd1;
          acc   <= '0;
        end else if (phase == 3'd4) begin
          bank[cur]    <= avg_trunc(acc_sum);
          valid_q[cur] <= 1'b1;
          sample_valid <= 1'b1;
          sample_chan  <= cur;
          sample_data  <= avg_trunc(acc_sum);
          bnd_q        <= 1'b1;
          phase        <= 3'd0;
          acc          <= '0;
          if (!cont_q && (nxt == first_q)) begin
            end_q <= 1'b1;
          end else begin
            cur         <= nxt;
            adc_address <= nxt;
          end
        end else begin
          acc   <= acc_sum;
          phase <= phase + 3'd1;
        end
`else
        if (state == WAIT_RDY) begin
          bank[prev]    <= adc_data;
          valid_q[prev] <= 1'b1;
          sample_valid  <= 1'b1;
          sample_chan   <= prev;
          sample_data   <= adc_data;
          if (final_q) end_q <= 1'b1;
        end
        prev <= cur;
        // Single pass: once the last channel is on the bus, keep it there for the flush frame.
        if (!final_q) begin
          if (!cont_q && (nxt == first_q)) begin
            final_q <= 1'b1;
          end else begin
            cur         <= nxt;
            adc_address <= nxt;
          end
        end
`endif
      end

      if (ack_exit) begin
        adc_ack <= 1'b0;
        if (finish) begin
          adc_en    <= 1'b0;
          busy      <= 1'b0;
          scan_done <= 1'b1;
        end
      end

      if (tmo) begin
        timeout_err <= 1'b1;
        adc_en      <= 1'b0;
        busy        <= 1'b0;
      end
    end
  end

  assign rd_data  = bank[rd_chan];
  assign rd_valid = valid_q[rd_chan];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural ADC frame model
// that returns 12'h100 + (address of the previous frame).
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  chan_mask = '0;
  logic        adc_ready = 1'b0;
  logic [11:0] adc_data = '0;
  logic [2:0]  rd_chan = '0;
  logic        adc_en, adc_ack, busy, sample_valid, scan_done, timeout_err, rd_valid;
  logic [2:0]  adc_address, sample_chan;
  logic [11:0] sample_data, rd_data;

  int checks = 0;
  int errors = 0;

  bit         model_en = 1'b0;
  int         dly = 3;
  int         hold = 1;
  int         mph = 0;
  int         mcnt = 0;
  int         hcnt = 0;
  logic [2:0] last_addr = '0;
  logic [2:0] frame_addr [16];
  int         nframes = 0;
  logic [2:0] s_chan [32];
  logic [11:0] s_data [32];
  int         nsamp = 0;
  int         ndone = 0;

  adc_scan_scheduler #(.TIMEOUT_CYCLES(64), .FIRST_CHAN(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .chan_mask(chan_mask), .adc_ready(adc_ready), .adc_data(adc_data),
    .adc_en(adc_en), .adc_address(adc_address), .adc_ack(adc_ack), .busy(busy),
    .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
    .scan_done(scan_done), .timeout_err(timeout_err), .rd_chan(rd_chan),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // ADC frame model
  always @(posedge clk) begin
    #1;
    if (model_en) begin
      if (!rst_n || !adc_en) begin
        adc_ready = 1'b0;
        mph = 0;
        mcnt = 0;
      end else begin
        case (mph)
          0: begin
            if (mcnt >= dly) begin
              if (nframes < 16) frame_addr[nframes] = adc_address;
              nframes++;
              adc_data  = 12'h100 + {9'd0, last_addr};
              last_addr = adc_address;
              adc_ready = 1'b1;
              mph = 1;
              hcnt = 0;
            end else begin
              mcnt++;
            end
          end
          1: begin
            if (adc_ack) begin
              hcnt++;
              if (hcnt >= hold) begin
                adc_ready = 1'b0;
                mph = 2;
              end
            end
          end
          default: begin
            if (!adc_ack) begin
              mph = 0;
              mcnt = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      if (nsamp < 32) begin
        s_chan[nsamp] = sample_chan;
        s_data[nsamp] = sample_data;
      end
      nsamp++;
    end
    if (scan_done) ndone++;
  end

  task automatic clear_mon();
    nsamp = 0;
    ndone = 0;
    nframes = 0;
    mph = 0;
    mcnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic c);
    @(negedge clk);
    chan_mask = m;
    continuous = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adc_en, adc_ack, busy, sample_valid, scan_done, timeout_err} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {adc_en, adc_ack, busy, sample_valid, scan_done, timeout_err});
    end
    checks++;
    if ({adc_address, sample_chan, sample_data} !== 18'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {adc_address, sample_chan, sample_data});
    end
    for (int i = 0; i < 8; i++) begin
      rd_chan = 3'(i);
      #1;
      checks++;
      if ({rd_valid, rd_data} !== 13'd0) begin
        errors++;
        $display("FAIL reset_bank ch%0d got %h want 0", i, {rd_valid, rd_data});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    logic [2:0] ea [3] = '{3'd0, 3'd2, 3'd2};
    int n;
    model_en = 1'b1; dly = 3; hold = 1;
    clear_mon();
    pulse_start(8'h05, 1'b0);
    for (n = 0; n < 2000 && busy; n++) begin @(negedge clk); #1; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_end busy got %b want 0", busy); end
    checks++;
    if (nframes !== 3) begin errors++; $display("FAIL single_frames got %0d want 3", nframes); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (frame_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL single_addr%0d got %0d want %0d", i, frame_addr[i], ea[i]);
      end
    end
    checks++;
    if (nsamp !== 2) begin errors++; $display("FAIL single_nsamp got %0d want 2", nsamp); end
    checks++;
    if ({s_chan[0], s_data[0], s_chan[1], s_data[1]} !== {3'd0, 12'h100, 3'd2, 12'h102}) begin
      errors++;
      $display("FAIL single_samples got %0d/%h %0d/%h want 0/100 2/102",
               s_chan[0], s_data[0], s_chan[1], s_data[1]);
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL single_done got %0d want 1", ndone); end
    for (int i = 0; i < 8; i++) begin
      rd_chan = 3'(i);
      #1;
      checks++;
      if (rd_valid !== ((i == 0) || (i == 2))) begin
        errors++;
        $display("FAIL single_rdvalid ch%0d got %b", i, rd_valid);
      end
    end
    rd_chan = 3'd2;
    #1;
    checks++;
    if (rd_data !== 12'h102) begin errors++; $display("FAIL single_rddata got %h want 102", rd_data); end
  endtask

  task automatic test_continuous_stop();
    int n;
    model_en = 1'b1; dly = 2; hold = 3;
    clear_mon();
    pulse_start(8'hFF, 1'b1);
    for (n = 0; n < 3000 && nsamp < 10; n++) begin @(negedge clk); #1; end
    checks++;
    if (nsamp !== 10) begin errors++; $display("FAIL cont_reach10 got %0d want 10", nsamp); end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (n = 0; n < 500 && busy; n++) begin @(negedge clk); #1; end
    checks++;
    if ({busy, adc_en} !== 2'b00) begin
      errors++;
      $display("FAIL cont_stop busy/en got %b want 00", {busy, adc_en});
    end
    checks++;
    if (nsamp !== 10) begin errors++; $display("FAIL cont_nsamp got %0d want 10", nsamp); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({s_chan[i], s_data[i]} !== {3'(i % 8), 12'h100 + 12'(i % 8)}) begin
        errors++;
        $display("FAIL cont_sample%0d got %0d/%h want %0d/%h", i, s_chan[i], s_data[i],
                 i % 8, 12'h100 + 12'(i % 8));
      end
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL cont_done got %0d want 1", ndone); end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, adc_en, ndone} !== {1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL idle_stop busy/en/done got %b%b/%0d want 00/1", busy, adc_en, ndone);
    end
  endtask

  task automatic test_ack_hold();
    int ackbad;
    model_en = 1'b0;
    adc_ready = 1'b0;
    clear_mon();
    pulse_start(8'h08, 1'b0);
    checks++;
    if (adc_address !== 3'd3) begin errors++; $display("FAIL ack_prime_addr got %0d want 3", adc_address); end
    repeat (2) @(negedge clk);
    adc_data = 12'h555;
    adc_ready = 1'b1;
    repeat (3) @(negedge clk);
    adc_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (adc_ack !== 1'b0) begin errors++; $display("FAIL ack_prime_release got %b want 0", adc_ack); end
    adc_data = 12'hABC;
    adc_ready = 1'b1;
    ackbad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (adc_ack !== 1'b1) ackbad++;
    end
    adc_ready = 1'b0;
    checks++;
    if (ackbad !== 0) begin errors++; $display("FAIL ack_held low_cycles got %0d want 0", ackbad); end
    @(negedge clk);
    #1;
    checks++;
    if (adc_ack !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", adc_ack); end
    checks++;
    if (nsamp !== 1) begin errors++; $display("FAIL ack_nsamp got %0d want 1", nsamp); end
    checks++;
    if ({s_chan[0], s_data[0]} !== {3'd3, 12'hABC}) begin
      errors++;
      $display("FAIL ack_sample got %0d/%h want 3/abc", s_chan[0], s_data[0]);
    end
    checks++;
    if ({busy, ndone} !== {1'b0, 32'd1}) begin
      errors++;
      $display("FAIL ack_end busy/done got %b/%0d want 0/1", busy, ndone);
    end
    rd_chan = 3'd3;
    #1;
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'hABC}) begin
      errors++;
      $display("FAIL ack_rd got %b/%h want 1/abc", rd_valid, rd_data);
    end
  endtask

  task automatic test_timeout();
    int n;
    model_en = 1'b0;
    adc_ready = 1'b0;
    clear_mon();
    pulse_start(8'h01, 1'b0);
    repeat (63) @(negedge clk);
    checks++;
    if ({timeout_err, adc_en} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_c63 err/en got %b want 01", {timeout_err, adc_en});
    end
    @(negedge clk);
    checks++;
    if ({timeout_err, adc_en, busy} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_c64 err/en/busy got %b want 100", {timeout_err, adc_en, busy});
    end
    #1;
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL tmo_done got %0d want 0", ndone); end
    model_en = 1'b1; dly = 2; hold = 1;
    clear_mon();
    pulse_start(8'h01, 1'b0);
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_clear err/busy got %b want 01", {timeout_err, busy});
    end
    for (n = 0; n < 500 && busy; n++) begin @(negedge clk); #1; end
    checks++;
    if ({busy, timeout_err, nsamp, ndone} !== {2'b00, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL tmo_rescan busy/err/nsamp/done got %b%b/%0d/%0d want 00/1/1",
               busy, timeout_err, nsamp, ndone);
    end
  endtask

  task automatic test_ignored_start();
    int n;
    model_en = 1'b0;
    adc_ready = 1'b0;
    clear_mon();
    pulse_start(8'h00, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, adc_en, adc_ack} !== 3'b000) begin
      errors++;
      $display("FAIL zero_mask busy/en/ack got %b want 000", {busy, adc_en, adc_ack});
    end
    pulse_start(8'h04, 1'b0);
    checks++;
    if ({busy, adc_address} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL busy_first busy/addr got %b/%0d want 1/2", busy, adc_address);
    end
    pulse_start(8'h01, 1'b1);
    checks++;
    if ({busy, adc_en, adc_address} !== {2'b11, 3'd2}) begin
      errors++;
      $display("FAIL busy_restart busy/en/addr got %b/%0d want 11/2", {busy, adc_en}, adc_address);
    end
    mph = 0;
    mcnt = 0;
    dly = 2; hold = 1;
    model_en = 1'b1;
    for (n = 0; n < 500 && busy; n++) begin @(negedge clk); #1; end
    checks++;
    if ({nframes, frame_addr[0], frame_addr[1]} !== {32'd2, 3'd2, 3'd2}) begin
      errors++;
      $display("FAIL busy_frames got %0d (%0d,%0d) want 2 (2,2)", nframes, frame_addr[0], frame_addr[1]);
    end
    checks++;
    if ({nsamp, s_chan[0], s_data[0], ndone} !== {32'd1, 3'd2, 12'h102, 32'd1}) begin
      errors++;
      $display("FAIL busy_sample got n%0d %0d/%h done%0d want n1 2/102 done1",
               nsamp, s_chan[0], s_data[0], ndone);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [2:0] ea [3] = '{3'd0, 3'd1, 3'd1};
    int n;
    model_en = 1'b1; dly = 2; hold = 10;
    clear_mon();
    pulse_start(8'h03, 1'b0);
    for (n = 0; n < 500 && !(adc_ack && nsamp >= 1); n++) begin @(negedge clk); #1; end
    checks++;
    if (adc_ack !== 1'b1) begin errors++; $display("FAIL rst_reach_ack got %b want 1", adc_ack); end
    rst_n = 1'b0;
    rd_chan = 3'd0;
    #1;
    checks++;
    if ({adc_en, adc_ack, busy, sample_valid, scan_done, timeout_err, adc_address} !== 9'd0) begin
      errors++;
      $display("FAIL rst_async_ctrl got %b want 0",
               {adc_en, adc_ack, busy, sample_valid, scan_done, timeout_err, adc_address});
    end
    checks++;
    if ({sample_data, rd_valid, rd_data} !== 25'd0) begin
      errors++;
      $display("FAIL rst_async_data got %h/%b/%h want 0/0/0", sample_data, rd_valid, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1;
    clear_mon();
    pulse_start(8'h03, 1'b0);
    checks++;
    if ({busy, adc_address} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL rst_rescan_prime busy/addr got %b/%0d want 1/0", busy, adc_address);
    end
    for (n = 0; n < 500 && busy; n++) begin @(negedge clk); #1; end
    checks++;
    if (nframes !== 3) begin errors++; $display("FAIL rst_rescan_frames got %0d want 3", nframes); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (frame_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL rst_rescan_addr%0d got %0d want %0d", i, frame_addr[i], ea[i]);
      end
    end
    checks++;
    if ({nsamp, s_chan[0], s_data[0], s_chan[1], s_data[1], ndone} !==
        {32'd2, 3'd0, 12'h100, 3'd1, 12'h101, 32'd1}) begin
      errors++;
      $display("FAIL rst_rescan_samples got n%0d %0d/%h %0d/%h done%0d want n2 0/100 1/101 done1",
               nsamp, s_chan[0], s_data[0], s_chan[1], s_data[1], ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous_stop();
    test_ack_hold();
    test_timeout();
    test_ignored_start();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
